// File: rtl/operand_pkg.sv
// Shared constants and state encoding for the operand store and the dot-product controller.
package operand_pkg;

  localparam int N_DEF = 8;
  localparam int D_DEF = 4;
  localparam int Q_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_X = 2'd1,
    LOAD_W = 2'd2,
    READY  = 2'd3
  } state_t;

  // Address width that never collapses to zero bits for single-entry dimensions.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/operand_store_responder_if.sv
// Host-load and operand-fetch signals between host/controller (master) and the operand store (slave).
interface operand_store_responder_if #(
  parameter int N  = 8,
  parameter int DW = 2,
  parameter int QW = 1
);
  logic          load_start;
  logic          load_valid;
  logic [N-1:0]  load_data;
  logic          load_ready;
  logic          loaded;
  logic          memRead_x;
  logic [QW-1:0] addr_x;
  logic [DW-1:0] index_d_x;
  logic          memRead_w;
  logic [QW-1:0] addr_w;
  logic [DW-1:0] index_d_w;
  logic [N-1:0]  x_data;
  logic          x_valid;
  logic [N-1:0]  w_data;
  logic          w_valid;
  logic          rd_err;

  modport master (
    output load_start, load_valid, load_data,
    output memRead_x, addr_x, index_d_x, memRead_w, addr_w, index_d_w,
    input  load_ready, loaded, x_data, x_valid, w_data, w_valid, rd_err
  );

  modport slave (
    input  load_start, load_valid, load_data,
    input  memRead_x, addr_x, index_d_x, memRead_w, addr_w, index_d_w,
    output load_ready, loaded, x_data, x_valid, w_data, w_valid, rd_err
  );
endinterface

// File: rtl/operand_store_responder_bank.sv
// One Q*D x N operand array: plain write port plus a registered, one-cycle read port.
module operand_bank
  import operand_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int D  = D_DEF,
  parameter int Q  = Q_DEF,
  parameter int DW = clog2_min1(D),
  parameter int QW = clog2_min1(Q),
  parameter int AW = clog2_min1(Q * D)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [N-1:0]  i_wdata,
  input  logic          i_en,
  input  logic          i_re,
  input  logic [QW-1:0] i_raddr_q,
  input  logic [DW-1:0] i_raddr_d,
  output logic [N-1:0]  o_rdata,
  output logic          o_rvalid,
  output logic          o_oob
);
  logic [N-1:0]  r_mem [Q*D];
  logic [N-1:0]  r_rdata;
  logic          r_rvalid;
  logic          w_bad;
  logic [AW-1:0] w_ridx;

  assign w_bad  = !i_en || (int'(i_raddr_q) >= Q) || (int'(i_raddr_d) >= D);
  assign w_ridx = AW'(int'(i_raddr_q) * D + int'(i_raddr_d));
  // Flagged in the request cycle so the sticky error lines up with the valid strobe.
  assign o_oob  = i_re & w_bad;

  // Storage is deliberately not reset; contents survive a reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: a bad request still returns a valid strobe, with zero data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata  <= {N{1'b0}};
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_re;
      if (i_re) begin
        r_rdata <= w_bad ? {N{1'b0}} : r_mem[w_ridx];
      end
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
endmodule

// File: rtl/operand_store_responder.sv
// Operand store: streams X then W from the host, then serves independent X/W operand reads.
module operand_store_responder
  import operand_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int D  = D_DEF,
  parameter int Q  = Q_DEF,
  parameter int DW = clog2_min1(D),
  parameter int QW = clog2_min1(Q)
) (
  input  logic i_clk,
  input  logic i_rst,
  operand_store_responder_if.slave bus
);
  localparam int AW = clog2_min1(Q * D);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_e_cnt;
  logic [QW-1:0] r_v_cnt;
  logic          r_rd_err;
  logic          w_in_load;
  logic          w_load_ready;
  logic          w_accept;
  logic          w_last;
  logic          w_cnt_clr;
  logic          w_loaded;
  logic          w_we_x;
  logic          w_we_w;
  logic          w_x_oob;
  logic          w_w_oob;
  logic [AW-1:0] w_waddr;

  assign w_in_load    = (r_state == LOAD_X) || (r_state == LOAD_W);
  // A restart cycle or reset cycle must not swallow a word into the old phase.
  assign w_load_ready = w_in_load & ~bus.load_start & ~i_rst;
  assign w_accept     = bus.load_valid & w_load_ready;
  assign w_last       = (r_e_cnt == DW'(D - 1)) && (r_v_cnt == QW'(Q - 1));
  assign w_loaded     = (r_state == READY);
  assign w_waddr      = AW'(int'(r_v_cnt) * D + int'(r_e_cnt));
  assign w_we_x       = w_accept && (r_state == LOAD_X);
  assign w_we_w       = w_accept && (r_state == LOAD_W);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; load_start always restarts at X element 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    case (r_state)
      IDLE, READY: begin
        if (bus.load_start) begin
          w_state_nxt = LOAD_X;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      LOAD_X, LOAD_W: begin
        if (bus.load_start) begin
          w_state_nxt = LOAD_X;
          w_cnt_clr   = 1'b1;
        end else if (w_accept && w_last) begin
          w_state_nxt = (r_state == LOAD_X) ? LOAD_W : READY;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_clr   = 1'b1;
      end
    endcase
  end

  // Row-major load counters: element index wraps into the vector index.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_cnt_clr) begin
      r_e_cnt <= {DW{1'b0}};
      r_v_cnt <= {QW{1'b0}};
    end else if (w_accept) begin
      if (r_e_cnt == DW'(D - 1)) begin
        r_e_cnt <= {DW{1'b0}};
        r_v_cnt <= (r_v_cnt == QW'(Q - 1)) ? {QW{1'b0}} : r_v_cnt + 1'b1;
      end else begin
        r_e_cnt <= r_e_cnt + 1'b1;
      end
    end
  end

  // Sticky read error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_err <= 1'b0;
    end else begin
      r_rd_err <= r_rd_err | w_x_oob | w_w_oob;
    end
  end

  operand_bank #(.N(N), .D(D), .Q(Q), .DW(DW), .QW(QW), .AW(AW)) u_bank_x (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (w_we_x),
    .i_waddr   (w_waddr),
    .i_wdata   (bus.load_data),
    .i_en      (w_loaded),
    .i_re      (bus.memRead_x),
    .i_raddr_q (bus.addr_x),
    .i_raddr_d (bus.index_d_x),
    .o_rdata   (bus.x_data),
    .o_rvalid  (bus.x_valid),
    .o_oob     (w_x_oob)
  );

  operand_bank #(.N(N), .D(D), .Q(Q), .DW(DW), .QW(QW), .AW(AW)) u_bank_w (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (w_we_w),
    .i_waddr   (w_waddr),
    .i_wdata   (bus.load_data),
    .i_en      (w_loaded),
    .i_re      (bus.memRead_w),
    .i_raddr_q (bus.addr_w),
    .i_raddr_d (bus.index_d_w),
    .o_rdata   (bus.w_data),
    .o_rvalid  (bus.w_valid),
    .o_oob     (w_w_oob)
  );

  assign bus.load_ready = w_load_ready;
  assign bus.loaded     = w_loaded;
  assign bus.rd_err     = r_rd_err;
endmodule

// File: tb/tb_operand_store_responder.sv
// Bench for operand_store_responder: directed scenarios plus random traffic against a phase/word-count model.
module tb_operand_store_responder;
  localparam int N = 8;
  localparam int D = 4;
  localparam int Q = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  // Model: phase 0 idle, 1 loading, 2 ready; k counts accepted words of the current load.
  int   m_phase = 0;
  int   m_k = 0;
  int   mx [Q*D];
  int   mw [Q*D];
  int   m_xd = 0, m_wd = 0, m_xv = 0, m_wv = 0, m_err = 0;

  always #5 clk = ~clk;

  operand_store_responder_if #(.N(N), .DW(2), .QW(1)) bus ();

  operand_store_responder #(.N(N), .D(D), .Q(Q)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'd0;
    bus.memRead_x  = 1'b0;
    bus.addr_x     = 1'b0;
    bus.index_d_x  = 2'd0;
    bus.memRead_w  = 1'b0;
    bus.addr_w     = 1'b0;
    bus.index_d_w  = 2'd0;
  endtask

  // Read-model helper: returns stored value or zero and flags an error.
  task automatic model_read(input int is_x, input int a, input int i, output int d);
    if (m_phase == 2 && a < Q && i < D) begin
      d = is_x ? mx[a*D+i] : mw[a*D+i];
    end else begin
      d = 0;
      m_err = 1;
    end
  endtask

  // One clock: check load_ready before the edge, advance the model, check registered outputs after.
  task automatic cycle();
    logic exp_rdy;
    int   d;
    #2;
    exp_rdy = (m_phase == 1) && !bus.load_start && !rst;
    check_eq("load_ready", 32'(bus.load_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_k = 0; m_xv = 0; m_wv = 0; m_xd = 0; m_wd = 0; m_err = 0;
    end else begin
      m_xv = bus.memRead_x ? 1 : 0;
      m_wv = bus.memRead_w ? 1 : 0;
      if (bus.memRead_x) begin
        model_read(1, int'(bus.addr_x), int'(bus.index_d_x), d);
        m_xd = d;
      end
      if (bus.memRead_w) begin
        model_read(0, int'(bus.addr_w), int'(bus.index_d_w), d);
        m_wd = d;
      end
      if (bus.load_start) begin
        m_phase = 1;
        m_k = 0;
      end else if (m_phase == 1 && bus.load_valid) begin
        if (m_k < Q*D) mx[m_k] = int'(bus.load_data);
        else           mw[m_k-Q*D] = int'(bus.load_data);
        m_k++;
        if (m_k == 2*Q*D) m_phase = 2;
      end
    end
    #1;
    check_eq("x_valid", 32'(bus.x_valid), 32'(m_xv));
    check_eq("w_valid", 32'(bus.w_valid), 32'(m_wv));
    check_eq("x_data", 32'(bus.x_data), 32'(m_xd));
    check_eq("w_data", 32'(bus.w_data), 32'(m_wd));
    check_eq("rd_err", 32'(bus.rd_err), 32'(m_err));
    check_eq("loaded", 32'(bus.loaded), 32'(m_phase == 2));
  endtask

  task automatic full_load(input int base);
    idle_inputs();
    bus.load_start = 1'b1;
    cycle();
    bus.load_start = 1'b0;
    for (int i = 0; i < 2*Q*D; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 8'(base + i);
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_loaded", 32'(bus.loaded), 32'd0);
    check_eq("reset_x_valid", 32'(bus.x_valid), 32'd0);
    check_eq("reset_rd_err", 32'(bus.rd_err), 32'd0);
    rst = 1'b0;

    // Read before any load is a bad request.
    bus.memRead_x = 1'b1;
    cycle();
    check_eq("early_x_data", 32'(bus.x_data), 32'd0);
    check_eq("early_rd_err", 32'(bus.rd_err), 32'd1);
    check_eq("early_loaded", 32'(bus.loaded), 32'd0);
    idle_inputs();
    cycle();

    full_load(1);
    check_eq("loaded_after_16", 32'(bus.loaded), 32'd1);
    bus.memRead_x = 1'b1; bus.addr_x = 1'b1; bus.index_d_x = 2'd2;
    bus.memRead_w = 1'b1; bus.addr_w = 1'b1; bus.index_d_w = 2'd3;
    cycle();
    check_eq("x12", 32'(bus.x_data), 32'd7);
    check_eq("w13", 32'(bus.w_data), 32'd16);
    check_eq("err_kept", 32'(bus.rd_err), 32'd1);
    idle_inputs();
    cycle();

    // Toggling load_valid: only valid cycles store.
    bus.load_start = 1'b1;
    cycle();
    bus.load_start = 1'b0;
    begin
      int w = 1;
      for (int i = 0; i < 2*2*Q*D; i++) begin
        bus.load_valid = (i % 2 == 0);
        bus.load_data  = (i % 2 == 0) ? 8'(w) : 8'hEE;
        if (i % 2 == 0) w++;
        cycle();
      end
    end
    idle_inputs();
    check_eq("loaded_toggle", 32'(bus.loaded), 32'd1);

    // load_start in READY alongside a W read: served from old contents.
    bus.load_start = 1'b1;
    bus.memRead_w = 1'b1; bus.addr_w = 1'b0; bus.index_d_w = 2'd0;
    cycle();
    check_eq("w00_old", 32'(bus.w_data), 32'd9);
    check_eq("loaded_drop", 32'(bus.loaded), 32'd0);
    idle_inputs();

    // Reset mid-load, then full reload.
    for (int i = 0; i < 5; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 8'(200 + i);
      cycle();
    end
    rst = 1'b1;
    #2;
    check_eq("ready_in_rst", 32'(bus.load_ready), 32'd0);
    cycle();
    rst = 1'b0;
    full_load(101);
    bus.memRead_x = 1'b1; bus.addr_x = 1'b0; bus.index_d_x = 2'd0;
    bus.memRead_w = 1'b1; bus.addr_w = 1'b1; bus.index_d_w = 2'd3;
    cycle();
    check_eq("x00_reload", 32'(bus.x_data), 32'd101);
    check_eq("w13_reload", 32'(bus.w_data), 32'd116);
    idle_inputs();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      rst            = ($urandom_range(0, 199) == 0);
      bus.load_start = ($urandom_range(0, 39) == 0);
      bus.load_valid = $urandom_range(0, 1);
      bus.load_data  = 8'($urandom);
      bus.memRead_x  = $urandom_range(0, 1);
      bus.addr_x     = 1'($urandom);
      bus.index_d_x  = 2'($urandom);
      bus.memRead_w  = $urandom_range(0, 1);
      bus.addr_w     = 1'($urandom);
      bus.index_d_w  = 2'($urandom);
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
